// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI arbiter: FSM state encoding,
// port geometry and small port-index helpers.
package dac_spi_pkg;

  localparam int NUM_PORTS          = 3;
  localparam int ADDR_W             = 7;
  localparam int DATA_W             = 8;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  // Next port index modulo 3; an out-of-range index wraps to port 0.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] p);
    logic [2:0] oh;
    case (p)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dac_spi_rr_pick.sv
// Round-robin requester selection: first active req searching upward from
// the port after the last owner, wrapping modulo 3.
module dac_spi_rr_pick
  import dac_spi_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] sel,
  output logic       valid
);

  logic [1:0] cand_s;
  logic       hit_s;

  // Walk the three candidates in priority order; the first hit sticks.
  always_comb begin
    sel    = 2'd0;
    valid  = 1'b0;
    hit_s  = 1'b0;
    cand_s = next_port(last);
    for (int i = 0; i < 3; i++) begin
      hit_s  = req[cand_s] & ~valid;
      sel    = hit_s ? cand_s : sel;
      valid  = valid | req[cand_s];
      cand_s = next_port(cand_s);
    end
  end

endmodule

// File: rtl/dac_spi_arbiter.sv
// Three-port arbiter in front of a single DAC SPI engine: round-robin grant,
// optional lock bursts, one transaction in flight, WAIT-state timeout.
module dac_spi_arbiter
  import dac_spi_pkg::*;
#(
  parameter int NUM_PORTS      = dac_spi_pkg::NUM_PORTS,
  parameter int TIMEOUT_CYCLES = dac_spi_pkg::DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        lock,
  input  logic [NUM_PORTS-1:0]        rw,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        done,
  output logic [NUM_PORTS-1:0]        err,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        write_req,
  output logic                        read_req,
  output logic [7:0]                  ad_rw_addr,
  output logic [DATA_W-1:0]           w_ad_data,
  input  logic                        r_w_end,
  input  logic [DATA_W-1:0]           r_ad_data
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:0]             owner_q, owner_d, last_q, last_d;
  logic                   rw_q, rw_d, tmo_q, tmo_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic                   busy_q, busy_d, wr_q, wr_d, rd_q, rd_d;
  logic [7:0]             ra_q, ra_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic [1:0]             pick_sel_s, src_s;
  logic                   pick_valid_s;

  dac_spi_rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .sel   (pick_sel_s),
    .valid (pick_valid_s)
  );

  // Next state, operand latching and registered output values.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    // In HOLD only the owner may start a new transaction.
    src_s   = (state_q == ST_HOLD) ? owner_q : pick_sel_s;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          owner_d = pick_sel_s;
          last_d  = pick_sel_s;
          rw_d    = rw[src_s];
          addr_d  = addr[src_s*ADDR_W +: ADDR_W];
          wdata_d = wdata[src_s*DATA_W +: DATA_W];
          tmo_d   = 1'b0;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (r_w_end) begin
          rdata_d = r_ad_data;
          done_d  = port_onehot(owner_q);
          state_d = ST_DONE;
        end else if (cnt_q == TMAX) begin
          rdata_d = '0;
          done_d  = port_onehot(owner_q);
          err_d   = port_onehot(owner_q);
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = (lock[owner_q] && !tmo_q) ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (req[owner_q]) begin
          rw_d    = rw[src_s];
          addr_d  = addr[src_s*ADDR_W +: ADDR_W];
          wdata_d = wdata[src_s*DATA_W +: DATA_W];
          tmo_d   = 1'b0;
          state_d = ST_ISSUE;
        end else if (!lock[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    gnt_d  = busy_d ? port_onehot(owner_d) : '0;
    wr_d   = (state_d == ST_ISSUE) && !rw_d;
    rd_d   = (state_d == ST_ISSUE) && rw_d;
    ra_d   = busy_d ? {rw_d, addr_d} : 8'h00;
    wd_d   = (busy_d && !rw_d) ? wdata_d : '0;
  end

  // State, operand and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ra_q    <= 8'h00;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      wd_q    <= wd_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign write_req  = wr_q;
  assign read_req   = rd_q;
  assign ad_rw_addr = ra_q;
  assign w_ad_data  = wd_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Scoreboard bench for dac_spi_arbiter with a behavioural SPI responder.
module tb_dac_spi_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, lock, rw;
  logic [20:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, done, err;
  logic [7:0]  rdata, ad_rw_addr, w_ad_data, r_ad_data;
  logic        busy, write_req, read_req, r_w_end;

  typedef struct {
    logic [1:0] port;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   cyc = 0, wr_pulses = 0, rd_pulses = 0, iss_cyc = 0, done_cyc = 0;
  logic [7:0] iss_ra = 8'h00, iss_wd = 8'h00;
  logic       rsp_en;
  int         rsp_delay;
  logic [7:0] rsp_data;

  dac_spi_arbiter #(.NUM_PORTS(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .rw(rw), .addr(addr),
    .wdata(wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .busy(busy), .write_req(write_req), .read_req(read_req),
    .ad_rw_addr(ad_rw_addr), .w_ad_data(w_ad_data), .r_w_end(r_w_end),
    .r_ad_data(r_ad_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each start pulse and the bus values presented with it.
  always @(negedge clk) begin
    if (write_req === 1'b1) wr_pulses <= wr_pulses + 1;
    if (read_req === 1'b1) rd_pulses <= rd_pulses + 1;
    if (write_req === 1'b1 || read_req === 1'b1) begin
      iss_cyc <= cyc;
      iss_ra  <= ad_rw_addr;
      iss_wd  <= w_ad_data;
    end
    if (write_req === 1'b1 && read_req === 1'b1) begin
      fails <= fails + 1;
      $display("FAIL both_pulses: write_req and read_req high together at cycle %0d", cyc);
    end
  end

  // SPI engine model: answer each start pulse rsp_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if ((write_req === 1'b1 || read_req === 1'b1) && rsp_en) begin
        repeat (rsp_delay) @(negedge clk);
        r_ad_data = rsp_data;
        r_w_end   = 1'b1;
        @(negedge clk);
        r_w_end   = 1'b0;
      end
    end
  end

  task automatic set_port(input int p, input logic r, input logic [6:0] a, input logic [7:0] d);
    rw[p]          = r;
    addr[p*7 +: 7] = a;
    wdata[p*8 +: 8] = d;
  endtask

  task automatic collect(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (|done) begin
        ok       = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({gnt, done, err} !== 9'b0) begin
      fails++; $display("FAIL reset_gnt_done_err: got %b required 0", {gnt, done, err});
    end
    tests++;
    if ({rdata, busy, write_req, read_req} !== 11'b0) begin
      fails++; $display("FAIL reset_rdata_ctl: got %h required 0", {rdata, busy, write_req, read_req});
    end
    tests++;
    if ({ad_rw_addr, w_ad_data} !== 16'b0) begin
      fails++; $display("FAIL reset_bus: got %h required 0", {ad_rw_addr, w_ad_data});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || gnt !== 3'b000) begin
      fails++; $display("FAIL idle_no_req: busy %b gnt %b required 0/000", busy, gnt);
    end
  endtask

  task automatic test_write();
    exp_t e;
    logic ok;
    int   w0, r0;
    e = '{port: 2'd1, rw: 1'b0, addr: 7'h18, wdata: 8'h02, rdata: 8'h00, err: 1'b0};
    rsp_delay = 10; rsp_data = 8'h00;
    w0 = wr_pulses; r0 = rd_pulses;
    set_port(1, 1'b0, 7'h18, 8'h02);
    req[1] = 1'b1;
    sb.push_back(e);
    collect(ok);
    e = sb.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL write_timeout: no done seen, required done %b", 3'b010);
    end else begin
      if (done !== 3'b010 || gnt !== 3'b010 || err !== 3'b000) begin
        fails++; $display("FAIL write_done: done %b gnt %b err %b required 010/010/000", done, gnt, err);
      end
      tests++;
      if (wr_pulses - w0 != 1 || rd_pulses != r0) begin
        fails++; $display("FAIL write_pulses: writes %0d reads %0d required 1/0", wr_pulses - w0, rd_pulses - r0);
      end
      tests++;
      if (iss_ra !== {e.rw, e.addr} || iss_wd !== e.wdata) begin
        fails++; $display("FAIL write_bus: addr %h data %h required %h %h", iss_ra, iss_wd, {e.rw, e.addr}, e.wdata);
      end
      tests++;
      if (done_cyc != iss_cyc + 11) begin
        fails++; $display("FAIL write_latency: done at +%0d required +11", done_cyc - iss_cyc);
      end
    end
    req[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || gnt !== 3'b000 || done !== 3'b000 || ad_rw_addr !== 8'h00) begin
      fails++; $display("FAIL write_release: busy %b gnt %b done %b addr %h required idle", busy, gnt, done, ad_rw_addr);
    end
  endtask

  task automatic test_read();
    exp_t e;
    logic ok;
    int   w0, r0;
    e = '{port: 2'd0, rw: 1'b1, addr: 7'h0E, wdata: 8'h77, rdata: 8'hA5, err: 1'b0};
    rsp_delay = 3; rsp_data = 8'hA5;
    w0 = wr_pulses; r0 = rd_pulses;
    set_port(0, 1'b1, 7'h0E, 8'h77);
    req[0] = 1'b1;
    sb.push_back(e);
    collect(ok);
    e = sb.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL read_timeout: no done seen, required done 001");
    end else begin
      if (done !== 3'b001 || rdata !== e.rdata) begin
        fails++; $display("FAIL read_done: done %b rdata %h required 001 %h", done, rdata, e.rdata);
      end
      tests++;
      if (rd_pulses - r0 != 1 || wr_pulses != w0) begin
        fails++; $display("FAIL read_pulses: reads %0d writes %0d required 1/0", rd_pulses - r0, wr_pulses - w0);
      end
      tests++;
      if (iss_ra !== 8'h8E || iss_wd !== 8'h00) begin
        fails++; $display("FAIL read_bus: addr %h data %h required 8e 00", iss_ra, iss_wd);
      end
    end
    req[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 3'b000 || rdata !== 8'hA5) begin
      fails++; $display("FAIL read_hold: done %b rdata %h required 000 a5", done, rdata);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    logic ok;
    pulse_reset();
    rsp_delay = 2;
    set_port(0, 1'b0, 7'h01, 8'h10);
    set_port(1, 1'b0, 7'h02, 8'h20);
    set_port(2, 1'b0, 7'h03, 8'h30);
    for (int k = 0; k < 6; k++) begin
      e = '{port: 2'(k % 3), rw: 1'b0, addr: 7'(k % 3 + 1), wdata: 8'((k % 3 + 1) * 16), rdata: 8'h00, err: 1'b0};
      sb.push_back(e);
    end
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      collect(ok);
      e = sb.pop_front();
      tests++;
      if (!ok) begin
        fails++; $display("FAIL rr_timeout: grant %0d never completed", k);
      end else if (done !== (3'b001 << e.port) || iss_ra !== {1'b0, e.addr} || iss_wd !== e.wdata) begin
        fails++; $display("FAIL rr_order: step %0d done %b addr %h required done %b addr %h", k, done, iss_ra, 3'b001 << e.port, {1'b0, e.addr});
      end
      if (k == 5) req = 3'b000;
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rr_idle: busy %b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic       ok, seen;
    logic [6:0] la [5];
    int         prev_done;
    la[0] = 7'h30; la[1] = 7'h31; la[2] = 7'h32; la[3] = 7'h33; la[4] = 7'h36;
    pulse_reset();
    rsp_delay = 1;
    prev_done = 0;
    for (int k = 0; k < 5; k++) begin
      e = '{port: 2'd2, rw: 1'b0, addr: la[k], wdata: 8'hC0 + 8'(k), rdata: 8'h00, err: 1'b0};
      sb.push_back(e);
    end
    e = '{port: 2'd0, rw: 1'b0, addr: 7'h05, wdata: 8'h55, rdata: 8'h00, err: 1'b0};
    sb.push_back(e);
    set_port(2, 1'b0, la[0], 8'hC0);
    lock[2] = 1'b1; req[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (gnt === 3'b100);
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL lock_first_grant: gnt %b required 100", gnt);
    end
    set_port(0, 1'b0, 7'h05, 8'h55);
    req[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      collect(ok);
      e = sb.pop_front();
      tests++;
      if (!ok) begin
        fails++; $display("FAIL lock_timeout: transaction %0d never completed", k);
      end else begin
        if (done !== (3'b001 << e.port) || iss_ra !== {1'b0, e.addr} || iss_wd !== e.wdata) begin
          fails++; $display("FAIL lock_order: step %0d done %b addr %h data %h required %b %h %h", k, done, iss_ra, iss_wd, 3'b001 << e.port, {1'b0, e.addr}, e.wdata);
        end
        if (k > 0) begin
          tests++;
          if (iss_cyc != prev_done + 2) begin
            fails++; $display("FAIL lock_gap: step %0d issue at +%0d after done required +2", k, iss_cyc - prev_done);
          end
        end
      end
      prev_done = done_cyc;
      if (k < 4) begin
        set_port(2, 1'b0, la[k+1], 8'hC0 + 8'(k + 1));
        @(negedge clk);
        tests++;
        if (gnt !== 3'b100 || busy !== 1'b1) begin
          fails++; $display("FAIL lock_hold: gnt %b busy %b required 100 1", gnt, busy);
        end
      end else if (k == 4) begin
        req[2] = 1'b0; lock[2] = 1'b0;
      end else begin
        req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic ok;
    rsp_en = 1'b0;
    e = '{port: 2'd1, rw: 1'b0, addr: 7'h11, wdata: 8'h99, rdata: 8'h00, err: 1'b1};
    sb.push_back(e);
    set_port(1, 1'b0, 7'h11, 8'h99);
    lock[1] = 1'b1; req[1] = 1'b1;
    collect(ok);
    e = sb.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL tmo_missing: no done seen after timeout");
    end else begin
      if (done !== 3'b010 || err !== 3'b010 || rdata !== e.rdata) begin
        fails++; $display("FAIL tmo_done: done %b err %b rdata %h required 010 010 00", done, err, rdata);
      end
      tests++;
      if (done_cyc != iss_cyc + TO + 1) begin
        fails++; $display("FAIL tmo_latency: done at +%0d required +%0d", done_cyc - iss_cyc, TO + 1);
      end
    end
    req[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || gnt !== 3'b000 || err !== 3'b000) begin
      fails++; $display("FAIL tmo_release: busy %b gnt %b err %b required idle", busy, gnt, err);
    end
    lock[1] = 1'b0;
    rsp_en = 1'b1; rsp_delay = 4; rsp_data = 8'h3C;
    e = '{port: 2'd2, rw: 1'b1, addr: 7'h22, wdata: 8'h00, rdata: 8'h3C, err: 1'b0};
    sb.push_back(e);
    set_port(2, 1'b1, 7'h22, 8'h00);
    req[2] = 1'b1;
    collect(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || done !== 3'b100 || err !== 3'b000 || rdata !== e.rdata) begin
      fails++; $display("FAIL tmo_recover: done %b err %b rdata %h required 100 000 %h", done, err, rdata, e.rdata);
    end
    req[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    logic ok, seen;
    int   p0;
    rsp_en = 1'b0;
    p0 = wr_pulses;
    set_port(0, 1'b0, 7'h44, 8'h12);
    req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (wr_pulses != p0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({gnt, done, err, busy, write_req, read_req} !== 12'b0 || {rdata, ad_rw_addr, w_ad_data} !== 24'b0) begin
      fails++; $display("FAIL rst_wait: gnt %b done %b busy %b rdata %h addr %h required all 0", gnt, done, busy, rdata, ad_rw_addr);
    end
    req[0] = 1'b0;
    rst = 1'b0;
    r_ad_data = 8'h77; r_w_end = 1'b1;
    @(negedge clk);
    r_w_end = 1'b0;
    @(negedge clk);
    tests++;
    if (rdata !== 8'h00 || done !== 3'b000 || busy !== 1'b0) begin
      fails++; $display("FAIL stray_end: rdata %h done %b busy %b required 00 000 0", rdata, done, busy);
    end
    rsp_en = 1'b1; rsp_delay = 2; rsp_data = 8'h5A;
    e = '{port: 2'd1, rw: 1'b1, addr: 7'h7F, wdata: 8'h00, rdata: 8'h5A, err: 1'b0};
    sb.push_back(e);
    set_port(1, 1'b1, 7'h7F, 8'h00);
    req[1] = 1'b1;
    collect(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || done !== 3'b010 || rdata !== e.rdata || iss_ra !== 8'hFF) begin
      fails++; $display("FAIL rst_recover: done %b rdata %h addr %h required 010 %h ff", done, rdata, iss_ra, e.rdata);
    end
    req[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; rw = '0; addr = '0; wdata = '0;
    r_w_end = 1'b0; r_ad_data = 8'h00;
    rsp_en = 1'b1; rsp_delay = 3; rsp_data = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
